// File: rtl/wb_cmd_pkg.sv
// Shared types and constants for the Wishbone command master.
package wb_cmd_pkg;

    localparam int unsigned WB_DW   = 32;
    localparam int unsigned WB_SELW = 4;

    // Master sequencing: idle/accepting, bus transfer in flight, response pending
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBus  = 2'b01,
        StResp = 2'b10
    } wb_state_e;

    // Response status codes reported on rsp_err_o
    typedef enum logic [1:0] {
        StsOk      = 2'b00,
        StsBusErr  = 2'b01,
        StsTimeout = 2'b10
    } wb_sts_e;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Cycle counter that flags expiry on the TIMEOUT_CYCLES-th enabled cycle.
module wb_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam bit          Enabled = (TIMEOUT_CYCLES != 0);
    localparam int unsigned CntW    = Enabled ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned LastInt = Enabled ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CntW-1:0] Last = CntW'(LastInt);

    logic [CntW-1:0] cnt_q;

    // Count holds the number of enabled cycles already completed; the current
    // cycle is the last allowed one when the count equals TIMEOUT_CYCLES-1.
    assign expired = Enabled && enable && (cnt_q == Last);

    // Clear has priority; stop counting once expired so the value cannot wrap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && !expired) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

endmodule

// File: rtl/wb_cmd_master.sv
// Command/response front end driving single classic Wishbone B4 transfers.
module wb_cmd_master
    import wb_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          RSP_ON_WRITE   = 1'b1
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_n_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic               cmd_we_i,
    input  logic [WB_DW-1:0]   cmd_adr_i,
    input  logic [WB_DW-1:0]   cmd_dat_i,
    input  logic [WB_SELW-1:0] cmd_sel_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [WB_DW-1:0]   rsp_dat_o,
    output logic [1:0]         rsp_err_o,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic               wbm_we_o,
    output logic [WB_SELW-1:0] wbm_sel_o,
    output logic [WB_DW-1:0]   wbm_adr_o,
    output logic [WB_DW-1:0]   wbm_dat_o,
    input  logic               wbm_ack_i,
    input  logic               wbm_err_i,
    input  logic [WB_DW-1:0]   wbm_dat_i
);

    wb_state_e          state_q;
    logic               cmd_ready_q;
    logic               cyc_q;
    logic               stb_q;
    logic               we_q;
    logic [WB_SELW-1:0] sel_q;
    logic [WB_DW-1:0]   adr_q;
    logic [WB_DW-1:0]   dat_q;
    logic               rsp_valid_q;
    logic [WB_DW-1:0]   rsp_dat_q;
    wb_sts_e            rsp_err_q;

    logic accept;
    logic in_bus;
    logic tmo_expired;

    // cmd_ready_q is only ever set while idle, so it doubles as the idle qualifier
    assign accept = cmd_valid_i && cmd_ready_q;
    assign in_bus = (state_q == StBus);

    wb_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_n_i),
        .clear  (accept),
        .enable (in_bus),
        .expired(tmo_expired)
    );

    // Main sequencer; every externally visible signal is a register
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= StsOk;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cmd_ready_q <= 1'b1;
                    if (accept) begin
                        cmd_ready_q <= 1'b0;
                        cyc_q       <= 1'b1;
                        stb_q       <= 1'b1;
                        we_q        <= cmd_we_i;
                        sel_q       <= cmd_sel_i;
                        adr_q       <= cmd_adr_i;
                        dat_q       <= cmd_dat_i;
                        state_q     <= StBus;
                    end
                end
                StBus: begin
                    if (wbm_ack_i || wbm_err_i || tmo_expired) begin
                        cyc_q <= 1'b0;
                        stb_q <= 1'b0;
                        // ack outranks err, which outranks the timeout
                        if (wbm_ack_i) begin
                            rsp_err_q <= StsOk;
                            rsp_dat_q <= we_q ? '0 : wbm_dat_i;
                        end else if (wbm_err_i) begin
                            rsp_err_q <= StsBusErr;
                            rsp_dat_q <= '0;
                        end else begin
                            rsp_err_q <= StsTimeout;
                            rsp_dat_q <= '0;
                        end
                        if (wbm_ack_i && we_q && !RSP_ON_WRITE) begin
                            cmd_ready_q <= 1'b1;
                            state_q     <= StIdle;
                        end else begin
                            rsp_valid_q <= 1'b1;
                            state_q     <= StResp;
                        end
                    end
                end
                StResp: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = stb_q;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;

endmodule

// File: doc/wb_cmd_master.md
WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning bus cycles waited for ack/err before abort; 0 disables the timeout.
REQ-002 SHALL have parameter RSP_ON_WRITE, default 1, meaning writes also produce a response beat.
REQ-003 SHALL use one clock and a synchronous, active-low reset: wb_clk_i  in  1  clock; wb_rst_n_i  in  1  synchronous active-low reset.
REQ-004 SHALL have cmd_valid_i  in  1  command offered.
REQ-005 SHALL have cmd_ready_o  out  1  command accepted this cycle.
REQ-006 SHALL have cmd_we_i  in  1  1 = write, 0 = read.
REQ-007 SHALL have cmd_adr_i  in  32  byte address.
REQ-008 SHALL have cmd_dat_i  in  32  write data.
REQ-009 SHALL have cmd_sel_i  in  4  byte lanes.
REQ-010 SHALL have rsp_valid_o  out  1  response available.
REQ-011 SHALL have rsp_ready_i  in  1  response consumed.
REQ-012 SHALL have rsp_dat_o  out  32  read data (0 for writes/errors).
REQ-013 SHALL have rsp_err_o  out  2  status: 00 ok, 01 bus err, 10 timeout.
REQ-014 SHALL have the Wishbone master port: wbm_cyc_o, wbm_stb_o, wbm_we_o (out, 1 each), wbm_sel_o (out, 4), wbm_adr_o, wbm_dat_o (out, 32), wbm_ack_i, wbm_err_i (in, 1 each), wbm_dat_i (in, 32); classic B4 single transfers only.

Function
REQ-015 SHALL implement states IDLE, BUS, RESP.
REQ-016 SHALL drive cmd_ready_o = 1 only in IDLE.
REQ-017 SHALL, on cmd_valid_i & cmd_ready_o, register we/adr/dat/sel and enter BUS; wbm_cyc_o/wbm_stb_o rise on the next cycle, driven from registers only.
REQ-018 SHALL hold cyc, stb, we, sel, adr and dat stable in BUS until termination.
REQ-019 SHALL terminate BUS on the first cycle with wbm_ack_i or wbm_err_i high; cyc/stb are low the following cycle.
REQ-020 SHALL capture wbm_dat_i into rsp_dat_o on read ack; rsp_dat_o = 0 for writes, errors and timeouts.
REQ-021 SHALL count cycles in BUS with a counter that clears on BUS entry; when the count reaches TIMEOUT_CYCLES without ack/err, terminate with status 10.
REQ-022 SHALL give priority ack > err > timeout when they coincide in one cycle.
REQ-023 SHALL, after termination, enter RESP with rsp_valid_o = 1 and hold the data/status stable until rsp_ready_i, then return to IDLE.
REQ-024 SHALL, when RSP_ON_WRITE = 0 and a write terminates with ok, return directly to IDLE without a response beat; err/timeout still respond.
REQ-025 SHALL have a minimum round trip, with a zero-wait slave, of: accept at cycle 0, cyc/stb at cycle 1, ack at cycle 1, rsp_valid_o at cycle 2, next cmd_ready_o at cycle 3 if the response is taken at cycle 2.
REQ-026 SHALL ignore wbm_ack_i and wbm_err_i outside BUS.
REQ-027 SHALL never accept a new command while a response is pending (one outstanding transfer).

Reset
REQ-028 SHALL, while wb_rst_n_i = 0 at a clock edge, enter IDLE and clear cyc, stb, we, sel, adr, dat, rsp_valid_o, rsp_dat_o, rsp_err_o and the timeout counter.
REQ-029 SHALL, on a reset asserted mid-BUS, have cyc/stb low after that edge; no response is produced for the aborted transfer.
REQ-030 SHALL hold cmd_ready_o = 0 during reset and drive it to 1 on the first edge after release.

Structure
REQ-031 SHALL place the state enum, the status codes (OK/BUSERR/TIMEOUT) and WB_DW = 32 / WB_SELW = 4 in the shared package wb_cmd_pkg.
REQ-032 SHALL implement the timeout counter as sub-module wb_timeout_ctr (clear, enable, expired), sized $clog2(TIMEOUT_CYCLES+1).

Verification
REQ-033 SHALL cover: read adr 0x3000_0004, slave acks after 3 wait cycles with 0xDEAD_BEEF -> cyc high 4 cycles, rsp_dat_o = 0xDEAD_BEEF, rsp_err_o = 00.
REQ-034 SHALL cover: write adr 0x3000_0000, dat 0x1234_5678, sel 0xF, zero-wait ack -> wbm_we_o = 1 with a stable bus, rsp_valid_o at cycle 2, rsp_err_o = 00, rsp_dat_o = 0.
REQ-035 SHALL cover: TIMEOUT_CYCLES = 8, slave never answers -> cyc drops after 8 BUS cycles, rsp_err_o = 10.
REQ-036 SHALL cover: ack and timeout in the same cycle -> rsp_err_o = 00 with the data captured.
REQ-037 SHALL cover: rsp_ready_i held low 5 cycles while cmd_valid_i = 1 -> cmd_ready_o = 0 and the response stable throughout.
REQ-038 SHALL cover: reset pulsed at the 2nd BUS cycle -> cyc/stb low next cycle, no rsp_valid_o, and a subsequent read completes normally.
